btn_press_classifier: RTL

//  Consumes the debounced level from the switch debouncer and classifies each press.

---
 rtl/btn_press_classifier_pkg.sv | 10 +
 rtl/btn_press_classifier_ms_timer.sv | 26 ++
 rtl/btn_press_classifier.sv | 68 ++++++
 3 files changed

// File: rtl/btn_press_classifier_pkg.sv
// btn_pkg: shared state encoding and timer sizing for the button press classifier
package btn_pkg;
  typedef enum logic [2:0] {ARM, IDLE, PRESS1, GAP, HOLD, PRESS2} state_t;
  function automatic int ms_width(input int long, input int dclk, input int rep);
    int m;
    m = long > dclk ? long : dclk;
    m = m > rep ? m : rep;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/btn_press_classifier_ms_timer.sv
// ms_timer: prescaled millisecond counter with synchronous clear, saturating at all-ones
module ms_timer #(
  parameter int MS_DIV = 50_000,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  output logic         ms_tick,
  output logic [W-1:0] ms
);
  localparam int PW = $clog2(MS_DIV);
  logic [PW-1:0] pre;
  assign ms_tick = pre == PW'(MS_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pre <= '0;
      ms  <= '0;
    end else if (ms_tick) begin
      pre <= '0;
      ms  <= &ms ? ms : ms + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end
endmodule

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: turns a debounced button level into short/long/double/repeat ticks
module btn_press_classifier
  import btn_pkg::*;
#(
  parameter int MS_DIV = 50_000,
  parameter int LONG_MS = 800,
  parameter int DCLK_MS = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic db_level,
  output logic short_tick,
  output logic long_tick,
  output logic double_tick,
  output logic repeat_tick,
  output logic busy
);
  localparam int W = ms_width(LONG_MS, DCLK_MS, REPEAT_MS);
  state_t state, nxt;
  logic clr, ms_tick, short_n, long_n, double_n, repeat_n;
  logic [W-1:0] ms;
  logic long_hit, dclk_hit, rep_hit;
  ms_timer #(.MS_DIV(MS_DIV), .W(W)) u_timer (
    .clk(clk), .reset(reset), .clr(clr), .ms_tick(ms_tick), .ms(ms)
  );
  assign long_hit = ms_tick && ms == W'(LONG_MS - 1);
  assign dclk_hit = ms_tick && ms == W'(DCLK_MS - 1);
  assign rep_hit  = ms_tick && ms == W'(REPEAT_MS - 1);
  // Release beats LONG_MS in PRESS1; a new press beats DCLK_MS in GAP.
  always_comb begin
    nxt = state;
    clr = 1'b0;
    short_n = 1'b0;
    long_n = 1'b0;
    double_n = 1'b0;
    repeat_n = 1'b0;
    case (state)
      ARM:    if (!db_level) nxt = IDLE;
      IDLE:   if (db_level) begin nxt = PRESS1; clr = 1'b1; end
      PRESS1: if (!db_level) begin nxt = GAP; clr = 1'b1; end
              else if (long_hit) begin nxt = HOLD; clr = 1'b1; long_n = 1'b1; end
      HOLD:   if (!db_level) nxt = IDLE;
              else if (rep_hit) begin clr = 1'b1; repeat_n = 1'b1; end
      GAP:    if (db_level) begin nxt = PRESS2; double_n = 1'b1; end
              else if (dclk_hit) begin nxt = IDLE; short_n = 1'b1; end
      PRESS2: if (!db_level) nxt = IDLE;
      default: nxt = ARM;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARM;
      short_tick <= 1'b0;
      long_tick <= 1'b0;
      double_tick <= 1'b0;
      repeat_tick <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      short_tick <= short_n;
      long_tick <= long_n;
      double_tick <= double_n;
      repeat_tick <= repeat_n;
      busy <= nxt != IDLE;
    end
  end
endmodule
